// File: rtl/regfile_pkg.sv
// Package: regfile_pkg
// Purpose: shared types and constants for the multi-port integer register
//          file (regfile_mp) and its read-port slice (rf_read_port).
// Contents:
//   clr_state_t  - clear engine state encoding (CLR_IDLE / CLR_RUN / CLR_DONE)
//   clog2_safe   - address width helper, never returns less than 1
//   XLEN_DEF     - default data width
//   NREGS_DEF    - default architectural register count
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_t;

  // A 1-bit address is the minimum so that tiny configurations still
  // produce legal vector widths.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// Module: rf_read_port
// Purpose: one combinational read port of the register file. Returns 0 for
//          x0, otherwise the highest-priority same-cycle write to the same
//          address (write-first bypass), otherwise the stored value.
// Ports:
//   rd_addr   in   AW            read address
//   rd_data   out  XLEN          read data
//   wr_en     in   NUM_WR        per-port write enables
//   wr_addr   in   NUM_WR*AW     write addresses, port w at [w*AW +: AW]
//   wr_data   in   NUM_WR*XLEN   write data, port w at [w*XLEN +: XLEN]
//   mem_flat  in   NREGS*XLEN    storage contents, entry r at [r*XLEN +: XLEN]
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_WR = 1,
  parameter int AW     = clog2_safe(NREGS)
) (
  input  logic [AW-1:0]          rd_addr,
  output logic [XLEN-1:0]        rd_data,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic [NREGS*XLEN-1:0]  mem_flat
);

  always_comb begin
    rd_data = '0;
    if (rd_addr != '0) begin
      rd_data = mem_flat[int'(rd_addr)*XLEN +: XLEN];
      // Ascending scan: a later (higher-index) matching port overrides an
      // earlier one, mirroring the write priority in the storage array.
      // rd_addr is non-zero here, so a match implies a non-x0 write.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr)) begin
          rd_data = wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Module: regfile_mp
// Purpose: parametrised multi-port integer register file. Writes commit on
//          posedge clk; reads are combinational with write-first bypass; x0
//          is hardwired to zero; a sequenced clear engine zeroes x1..xN-1
//          one register per cycle for context flush.
// Optional feature: define REGFILE_DEBUG_EN to add the dbg_addr/dbg_data
//          probe (raw storage read, no bypass). Undefined: ports absent.
// Ports:
//   clk        in   1             clock, all state on posedge
//   reset      in   1             asynchronous active-low reset
//   rd_addr    in   NUM_RD*AW     read addresses, port p at [p*AW +: AW]
//   rd_data    out  NUM_RD*XLEN   read data, port p at [p*XLEN +: XLEN]
//   wr_en      in   NUM_WR        per-port write enable
//   wr_addr    in   NUM_WR*AW     write addresses
//   wr_data    in   NUM_WR*XLEN   write data
//   clr_req    in   1             start sequenced clear (level, sampled in IDLE)
//   clr_busy   out  1             clear engine active (CLR_RUN or CLR_DONE)
//   clr_done   out  1             one-cycle pulse after last register cleared
//   dbg_addr   in   AW            (REGFILE_DEBUG_EN) probe address
//   dbg_data   out  XLEN          (REGFILE_DEBUG_EN) probe data, no bypass
//   clr_state  out  clr_state_t   clear engine state, for observation
// Handshake: clr_req is a level request with no ready; it is only looked at
//   in CLR_IDLE, so holding it high restarts a clear one cycle after the
//   CLR_DONE pulse, and asserting it while clr_busy=1 has no effect.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = clog2_safe(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   clr_done,
`ifdef REGFILE_DEBUG_EN
  input  logic [AW-1:0]          dbg_addr,
  output logic [XLEN-1:0]        dbg_data,
`endif
  output clr_state_t             clr_state
);

  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST = AW'(NREGS - 1);

  logic [XLEN-1:0]       mem [NREGS];
  logic [NREGS*XLEN-1:0] mem_flat;

  clr_state_t    state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          clr_step;

  // ---------------- clear engine ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLR_IDLE;
      idx   <= IDX_ONE;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_step  = 1'b0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    unique case (state)
      CLR_IDLE: begin
        if (clr_req) begin
          state_nxt = CLR_RUN;
          idx_nxt   = IDX_ONE;
        end
      end
      CLR_RUN: begin
        clr_busy = 1'b1;
        clr_step = 1'b1;
        // Stop on the last index rather than incrementing, so idx never
        // wraps back through x0.
        if (idx == IDX_LAST) begin
          state_nxt = CLR_DONE;
          idx_nxt   = IDX_ONE;
        end else begin
          idx_nxt = idx + IDX_ONE;
        end
      end
      CLR_DONE: begin
        clr_busy  = 1'b1;
        clr_done  = 1'b1;
        state_nxt = CLR_IDLE;
      end
      default: begin
        state_nxt = CLR_IDLE;
        idx_nxt   = IDX_ONE;
      end
    endcase
  end

  assign clr_state = state;

  // ---------------- storage ----------------
  // Assignment order sets priority: the clear step first, then write ports
  // in ascending index, so a user write beats the clear and port 1 beats
  // port 0 when they target the same register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      if (clr_step) begin
        mem[idx] <= '0;
      end
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
          mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_flat
    assign mem_flat[r*XLEN +: XLEN] = mem[r];
  end

  // ---------------- read ports ----------------
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NUM_WR (NUM_WR),
      .AW     (AW)
    ) u_rd (
      .rd_addr  (rd_addr[p*AW +: AW]),
      .rd_data  (rd_data[p*XLEN +: XLEN]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .mem_flat (mem_flat)
    );
  end

`ifdef REGFILE_DEBUG_EN
  // Raw storage view: shows committed contents only, never the bypass.
  assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                   clk;
  logic                   reset;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   clr_req;
  logic                   clr_busy;
  logic                   clr_done;
  clr_state_t             clr_state;
`ifdef REGFILE_DEBUG_EN
  logic [AW-1:0]          dbg_addr;
  logic [XLEN-1:0]        dbg_data;
`endif

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  regfile_mp #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
`ifdef REGFILE_DEBUG_EN
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
`endif
    .clr_state (clr_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [XLEN-1:0] act);
    logic [XLEN-1:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expected queue empty, got 0x%08h", name, act);
    end else begin
      exp = exp_q.pop_front();
      check(name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_wr(input logic [1:0] en, input logic [AW-1:0] a0,
                          input logic [XLEN-1:0] d0, input logic [AW-1:0] a1,
                          input logic [XLEN-1:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic drive_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Read every register x1..x31 on both ports (port 1 walks downwards) and
  // compare against values pushed by the caller for port 0 then port 1.
  task automatic readback(input string name);
    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk);
      drive_wr(2'b00, '0, '0, '0, '0);
      drive_rd(AW'(i), AW'(NREGS - i));
      #1;
      check_q({name, "_p0"}, rd_data[0 +: XLEN]);
      check_q({name, "_p1"}, rd_data[XLEN +: XLEN]);
    end
  endtask

  // Start a clear and watch it. action: 0 plain, 1 writes at idx 10,
  // 2 async reset at idx 15, 3 read-during-clear check at idx 1.
  // Entered and left on a negedge.
  task automatic run_clear(input int action, output int busy_cnt,
                           output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    clr_req  = 1'b1;
    @(negedge clk);
    clr_req  = 1'b0;
    for (int c = 0; c < 45; c++) begin
      #1;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (action == 3 && busy_cnt == 1 && clr_busy) begin
        drive_rd(AW'(1), AW'(31));
        #1;
        check("clr_rd_x1_not_bypassed", rd_data[0 +: XLEN], 32'd1);
        check("clr_rd_x31", rd_data[XLEN +: XLEN], 32'd31);
        check("clr_state_run", XLEN'(clr_state), XLEN'(CLR_RUN));
      end
      if (action == 1 && busy_cnt == 10 && clr_busy) begin
        drive_wr(2'b11, AW'(10), 32'hAB, AW'(3), 32'hCD);
      end
      if (action == 1 && busy_cnt == 11) begin
        drive_wr(2'b00, '0, '0, '0, '0);
      end
      if (action == 2 && busy_cnt == 15 && reset) begin
        reset = 1'b0;
        #1;
        check("rst_mid_clr_busy", XLEN'(clr_busy), '0);
        check("rst_mid_clr_state", XLEN'(clr_state), XLEN'(CLR_IDLE));
        @(posedge clk);
        #2;
        reset = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]      en;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] exp0;
    logic [XLEN-1:0] exp1;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int busy_cnt;
    int done_cnt;

    vecs[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{2'b11, 5'd7,  32'h1111,     5'd7,  32'h2222,     5'd7,  5'd5,  32'h2222,     32'hDEADBEEF};
    vecs[3] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd7,  32'h2222,     32'h2222};
    vecs[4] = '{2'b11, 5'd0,  32'hFFFF,     5'd0,  32'hFFFF,     5'd0,  5'd0,  32'h0,        32'h0};
    vecs[5] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0};
    vecs[6] = '{2'b11, 5'd31, 32'h12345678, 5'd1,  32'hA5A5A5A5, 5'd31, 5'd1,  32'h12345678, 32'hA5A5A5A5};
    vecs[7] = '{2'b11, 5'd1,  32'h1,        5'd2,  32'h2,        5'd1,  5'd2,  32'h1,        32'h2};
    vecs[8] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd1,  5'd31, 32'h1,        32'h12345678};
    vecs[9] = '{2'b01, 5'd9,  32'h99,       5'd9,  32'hBAD,      5'd9,  5'd9,  32'h99,       32'h99};

    reset   = 1'b0;
    clr_req = 1'b0;
    drive_wr(2'b00, '0, '0, '0, '0);
    drive_rd(AW'(5), AW'(31));
`ifdef REGFILE_DEBUG_EN
    dbg_addr = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_rd0", rd_data[0 +: XLEN], '0);
    check("rst_rd1", rd_data[XLEN +: XLEN], '0);
    check("rst_busy", XLEN'(clr_busy), '0);
    check("rst_done", XLEN'(clr_done), '0);
    check("rst_state", XLEN'(clr_state), XLEN'(CLR_IDLE));

    // Table: same-cycle bypass checked at negedge+1, commit at posedge.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      drive_wr(vecs[v].en, vecs[v].wa0, vecs[v].wd0, vecs[v].wa1, vecs[v].wd1);
      drive_rd(vecs[v].ra0, vecs[v].ra1);
      #1;
      check($sformatf("vec%0d_rd0", v), rd_data[0 +: XLEN], vecs[v].exp0);
      check($sformatf("vec%0d_rd1", v), rd_data[XLEN +: XLEN], vecs[v].exp1);
    end

    // Async reset mid-run after writes.
    @(negedge clk);
    drive_wr(2'b00, '0, '0, '0, '0);
    drive_rd(AW'(5), AW'(7));
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_rd0", rd_data[0 +: XLEN], '0);
    check("async_rst_rd1", rd_data[XLEN +: XLEN], '0);
    check("async_rst_busy", XLEN'(clr_busy), '0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i < NREGS; i++) begin
      exp_q.push_back('0);
      exp_q.push_back('0);
    end
    readback("post_rst");

    // Fill x1..x31 with i, then a full clear.
    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk);
      drive_wr(2'b01, AW'(i), XLEN'(i), '0, '0);
    end
    @(negedge clk);
    drive_wr(2'b00, '0, '0, '0, '0);
    run_clear(3, busy_cnt, done_cnt);
    check("clr_busy_cycles", XLEN'(busy_cnt), 32'd32);
    check("clr_done_pulses", XLEN'(done_cnt), 32'd1);
    check("clr_end_state", XLEN'(clr_state), XLEN'(CLR_IDLE));
    for (int i = 1; i < NREGS; i++) begin
      exp_q.push_back('0);
      exp_q.push_back('0);
    end
    readback("post_clr");

    // Writes during clear at idx 10.
    drive_wr(2'b11, AW'(20), 32'h2020, AW'(3), 32'h3333);
    @(negedge clk);
    drive_wr(2'b00, '0, '0, '0, '0);
    run_clear(1, busy_cnt, done_cnt);
    check("clr2_done_pulses", XLEN'(done_cnt), 32'd1);
    drive_rd(AW'(10), AW'(3));
    #1;
    check("clr2_x10_user_wins", rd_data[0 +: XLEN], 32'hAB);
    check("clr2_x3_kept", rd_data[XLEN +: XLEN], 32'hCD);
    @(negedge clk);
    drive_rd(AW'(20), AW'(0));
    #1;
    check("clr2_x20_cleared", rd_data[0 +: XLEN], '0);

    // Async reset at idx 15 of a new clear.
    @(negedge clk);
    run_clear(2, busy_cnt, done_cnt);
    check("clr3_no_done", XLEN'(done_cnt), '0);
    check("clr3_busy_cycles", XLEN'(busy_cnt), 32'd15);
    for (int i = 1; i < NREGS; i++) begin
      exp_q.push_back('0);
      exp_q.push_back('0);
    end
    readback("post_rst_clr");

`ifdef REGFILE_DEBUG_EN
    @(negedge clk);
    dbg_addr = AW'(6);
    drive_wr(2'b01, AW'(6), 32'h42, '0, '0);
    #1;
    check("dbg_same_cycle", dbg_data, '0);
    @(negedge clk);
    drive_wr(2'b00, '0, '0, '0, '0);
    #1;
    check("dbg_next_cycle", dbg_data, 32'h42);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
